vga_line_sequencer: RTL and testbench

//   Parametrised VGA raster timing generator plus per-line render scheduler.

---
 rtl/vga_line_sequencer_if.sv | 14 +
 rtl/vga_line_sequencer.sv | 163 ++++++++++++++++
 tb/tb_vga_line_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_line_sequencer_if.sv
// Render-engine handshake between the line sequencer (master) and the render engines (slave).
// eng_start[k] and eng_done[k] are one-clock pulses; eng_abort tells all engines to drop the current line.
interface vga_line_sequencer_if #(
   parameter int N_ENG = 2,
   parameter int VW    = 10
);
   logic [N_ENG-1:0] eng_start;
   logic [N_ENG-1:0] eng_done;
   logic             eng_abort;
   logic [VW-1:0]    render_line;

   modport master (output eng_start, output eng_abort, output render_line, input eng_done);
   modport slave  (input eng_start, input eng_abort, input render_line, output eng_done);
endinterface

// File: rtl/vga_line_sequencer.sv
// VGA raster timing generator with a per-line render scheduler for N_ENG engines,
// ping-pong buffer select and render-underrun accounting.
module vga_line_sequencer #(
   parameter int CLK_PER_PIX = 2,
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int N_ENG       = 2,
   parameter int UCNT_W      = 16,
   localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int HW         = $clog2(H_TOTAL),
   localparam int VW         = $clog2(V_TOTAL)
) (
   input  logic              clk,
   input  logic              reset,
   output logic              pix_en,
   output logic [HW-1:0]     pix_x,
   output logic [VW-1:0]     pix_y,
   output logic              hsync_n,
   output logic              vsync_n,
   output logic              blank_n,
   output logic              frame_start,
   vga_line_sequencer_if.master eng,
   output logic              buf_sel,
   output logic              underrun,
   output logic [UCNT_W-1:0] underrun_cnt,
   input  logic              underrun_clr,
   output logic [1:0]        state_dbg
);
   localparam int DW = (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;
   localparam int KW = (N_ENG > 1) ? $clog2(N_ENG) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_READY = 2'd3
   } state_t;

   logic [DW-1:0] div;
   state_t        state, state_nx;
   logic [KW-1:0] k, k_nx;
   logic          ls, le, sched, swap, load_line, awaited_done, last_k;
   logic [VW-1:0] next_render;
   logic [N_ENG-1:0] k_onehot;

   assign pix_en = (div == DW'(CLK_PER_PIX - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div   <= '0;
         pix_x <= '0;
         pix_y <= '0;
      end else if (pix_en) begin
         div <= '0;
         if (pix_x == HW'(H_TOTAL - 1)) begin
            pix_x <= '0;
            pix_y <= (pix_y == VW'(V_TOTAL - 1)) ? '0 : pix_y + VW'(1);
         end else begin
            pix_x <= pix_x + HW'(1);
         end
      end else begin
         div <= div + DW'(1);
      end
   end

   assign hsync_n = !((pix_x >= HW'(H_ACTIVE + H_FP)) && (pix_x < HW'(H_ACTIVE + H_FP + H_SYNC)));
   assign vsync_n = !((pix_y >= VW'(V_ACTIVE + V_FP)) && (pix_y < VW'(V_ACTIVE + V_FP + V_SYNC)));
   // Coordinates sit at (0,0) during reset; gating keeps blank/frame_start quiet there.
   assign blank_n     = !reset && (pix_x < HW'(H_ACTIVE)) && (pix_y < VW'(V_ACTIVE));
   assign ls          = (div == '0) && (pix_x == '0);
   assign le          = pix_en && (pix_x == HW'(H_TOTAL - 1));
   assign frame_start = !reset && ls && (pix_y == '0);

   // The line after pix_y is rendered now; the last blanking line prepares line 0.
   assign sched       = (pix_y <= VW'(V_ACTIVE - 2)) || (pix_y == VW'(V_TOTAL - 1));
   assign next_render = (pix_y == VW'(V_TOTAL - 1)) ? '0 : pix_y + VW'(1);

   assign k_onehot     = N_ENG'(1) << k;
   assign awaited_done = |(eng.eng_done & k_onehot);
   assign last_k       = (k == KW'(N_ENG - 1));
   assign state_dbg    = state;

   always_comb begin
      state_nx      = state;
      k_nx          = k;
      eng.eng_start = '0;
      eng.eng_abort = 1'b0;
      underrun      = 1'b0;
      swap          = 1'b0;
      load_line     = 1'b0;
      case (state)
         S_IDLE: begin
            if (ls && sched) begin
               state_nx  = S_START;
               k_nx      = '0;
               load_line = 1'b1;
            end
         end
         S_START: begin
            if (le) begin
               underrun      = 1'b1;
               eng.eng_abort = 1'b1;
               state_nx      = S_IDLE;
            end else begin
               eng.eng_start = k_onehot;
               state_nx      = S_WAIT;
            end
         end
         S_WAIT: begin
            // Last engine finishing on the line-end clock still counts as in time.
            if (awaited_done && last_k) begin
               if (le) begin
                  swap     = 1'b1;
                  state_nx = S_IDLE;
               end else begin
                  state_nx = S_READY;
               end
            end else if (le) begin
               underrun      = 1'b1;
               eng.eng_abort = 1'b1;
               state_nx      = S_IDLE;
            end else if (awaited_done) begin
               k_nx     = k + KW'(1);
               state_nx = S_START;
            end
         end
         S_READY: begin
            if (le) begin
               swap     = 1'b1;
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= S_IDLE;
         k               <= '0;
         buf_sel         <= 1'b0;
         eng.render_line <= '0;
         underrun_cnt    <= '0;
      end else begin
         state <= state_nx;
         k     <= k_nx;
         if (load_line) eng.render_line <= next_render;
         if (swap) buf_sel <= ~buf_sel;
         if (underrun_clr) begin
            underrun_cnt <= underrun ? UCNT_W'(1) : '0;
         end else if (underrun && (underrun_cnt != '1)) begin
            underrun_cnt <= underrun_cnt + UCNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_vga_line_sequencer.sv
// Bench for vga_line_sequencer in a small raster (14x7, 2 clk/pixel, 2 engines, 2-bit underrun count).
module tb_vga_line_sequencer;
   localparam int CPP   = 2;
   localparam int HA    = 8;
   localparam int HF    = 2;
   localparam int HS    = 2;
   localparam int HB    = 2;
   localparam int VA    = 4;
   localparam int VF    = 1;
   localparam int VS    = 1;
   localparam int VB    = 1;
   localparam int NE    = 2;
   localparam int UW    = 2;
   localparam int HT    = HA + HF + HS + HB;
   localparam int VT    = VA + VF + VS + VB;
   localparam int HW    = $clog2(HT);
   localparam int VW    = $clog2(VT);
   localparam int LINE  = HT * CPP;
   localparam int FRAME = LINE * VT;
   localparam int UMAX  = (1 << UW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          pix_en, hsync_n, vsync_n, blank_n, frame_start, buf_sel, underrun;
   logic          underrun_clr;
   logic [HW-1:0] pix_x;
   logic [VW-1:0] pix_y;
   logic [UW-1:0] underrun_cnt;
   logic [1:0]    state_dbg;

   always #5 clk = ~clk;

   vga_line_sequencer_if #(.N_ENG(NE), .VW(VW)) eng_if ();

   vga_line_sequencer #(
      .CLK_PER_PIX(CPP), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .N_ENG(NE), .UCNT_W(UW)
   ) dut (
      .clk(clk), .reset(reset), .pix_en(pix_en), .pix_x(pix_x), .pix_y(pix_y),
      .hsync_n(hsync_n), .vsync_n(vsync_n), .blank_n(blank_n), .frame_start(frame_start),
      .eng(eng_if), .buf_sel(buf_sel), .underrun(underrun), .underrun_cnt(underrun_cnt),
      .underrun_clr(underrun_clr), .state_dbg(state_dbg)
   );

   int checks = 0;
   int errors = 0;
   logic [15:0] start_q[$];
   logic [1:0]  exp_q[$];

   // cycle index since reset release; the raster position is derived from it directly
   int cyc;
   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   bit            mon_en = 1'b0;
   int            dly0 = 3, dly1 = 3;
   bit            d1_le = 1'b0, spur = 1'b0;
   bit            clr_arm = 1'b0;
   int            clr_y = 0, clr_pos = 0;
   logic          m_buf = 1'b0;
   int            m_cnt = 0;
   logic [VW-1:0] m_render = '0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h cyc=%0d t=%0t", tag, act, exp, cyc, $time);
      end
   endtask

   function automatic bit sched_line(input int y);
      return (y <= VA - 2) || (y == VT - 1);
   endfunction

   task automatic reset_checks(input string tag);
      check_eq({tag, "_pix_x"}, 32'(pix_x), 0);
      check_eq({tag, "_pix_y"}, 32'(pix_y), 0);
      check_eq({tag, "_pix_en"}, 32'(pix_en), 0);
      check_eq({tag, "_sync"}, {hsync_n, vsync_n, blank_n}, 3'b110);
      check_eq({tag, "_frame_start"}, 32'(frame_start), 0);
      check_eq({tag, "_eng_start"}, 32'(eng_if.eng_start), 0);
      check_eq({tag, "_eng_abort"}, 32'(eng_if.eng_abort), 0);
      check_eq({tag, "_render_line"}, 32'(eng_if.render_line), 0);
      check_eq({tag, "_buf_sel"}, 32'(buf_sel), 0);
      check_eq({tag, "_underrun"}, 32'(underrun), 0);
      check_eq({tag, "_underrun_cnt"}, 32'(underrun_cnt), 0);
      check_eq({tag, "_state"}, 32'(state_dbg), 0);
   endtask

   task automatic to_line_y(input int y);
      bit hit = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(posedge clk); #1;
         if (cyc % FRAME == y * LINE) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) check_eq("timeout_line", 0, 1);
   endtask

   task automatic wait_pos(input int p);
      bit hit = 1'b0;
      for (int i = 0; i < 2 * LINE; i++) begin
         @(posedge clk); #1;
         if (cyc % LINE == p) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) check_eq("timeout_pos", 0, 1);
   endtask

   // Engine driver plus cycle monitor: inputs for a cycle are driven at the falling edge,
   // outputs are sampled 1 time unit later.
   initial begin
      int pos, x, y, cnt0, cnt1, cnt_sp;
      logic [NE-1:0] done;
      logic u_exp, s_exp;
      eng_if.eng_done = '0;
      underrun_clr    = 1'b0;
      cnt0 = 0; cnt1 = 0; cnt_sp = 0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            eng_if.eng_done = '0;
            underrun_clr    = 1'b0;
            cnt0 = 0; cnt1 = 0; cnt_sp = 0;
            continue;
         end
         pos = cyc % LINE;
         x   = pos / CPP;
         y   = (cyc / LINE) % VT;
         done = '0;
         if (cnt0 > 0) begin
            cnt0--;
            if (cnt0 == 0) begin
               done[0] = 1'b1;
               start_q.push_back({8'h02, 8'(pos + 1)});
            end
         end
         if (cnt1 > 0) begin
            cnt1--;
            if (cnt1 == 0) done[1] = 1'b1;
         end
         if (cnt_sp > 0) begin
            cnt_sp--;
            if (cnt_sp == 0) done[1] = 1'b1;
         end
         if (d1_le && pos == LINE - 1) done[1] = 1'b1;
         eng_if.eng_done = done;
         underrun_clr = clr_arm && (y == clr_y) && (pos == clr_pos);
         if (underrun_clr) clr_arm = 1'b0;

         if (pos == 0 && sched_line(y)) begin
            u_exp = (dly0 == 0) || (dly1 == 0 && !d1_le);
            exp_q.push_back({u_exp, !u_exp});
            start_q.push_back({8'h01, 8'd1});
         end
         u_exp = 1'b0;
         s_exp = 1'b0;
         if (pos == LINE - 1 && sched_line(y)) begin
            if (exp_q.size() == 0) check_eq("exp_q_empty", 0, 1);
            else {u_exp, s_exp} = exp_q.pop_front();
         end
         #1;
         check_eq("pix_en", 32'(pix_en), 32'(pos % CPP == CPP - 1));
         check_eq("pix_x", 32'(pix_x), 32'(x));
         check_eq("pix_y", 32'(pix_y), 32'(y));
         check_eq("sync", {hsync_n, vsync_n, blank_n},
                  {!(x >= HA + HF && x < HA + HF + HS), !(y >= VA + VF && y < VA + VF + VS),
                   (x < HA) && (y < VA)});
         check_eq("frame_start", 32'(frame_start), 32'(cyc % FRAME == 0));
         check_eq("underrun", 32'(underrun), 32'(u_exp));
         check_eq("eng_abort", 32'(eng_if.eng_abort), 32'(u_exp));
         check_eq("buf_sel", 32'(buf_sel), 32'(m_buf));
         check_eq("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
         check_eq("render_line", 32'(eng_if.render_line), 32'(m_render));
         if (eng_if.eng_start != '0 || (start_q.size() > 0 && start_q[0][7:0] == 8'(pos))) begin
            if (start_q.size() == 0) check_eq("eng_start_unexpected", {8'(eng_if.eng_start), 8'(pos)}, 0);
            else check_eq("eng_start", {8'(eng_if.eng_start), 8'(pos)}, start_q.pop_front());
         end
         if (eng_if.eng_start[0]) begin
            cnt0 = dly0;
            if (spur) cnt_sp = 1;
         end
         if (eng_if.eng_start[1]) cnt1 = dly1;
         if (eng_if.eng_abort) begin
            cnt0 = 0;
            cnt1 = 0;
         end
         if (pos == 0 && sched_line(y)) m_render = (y == VT - 1) ? '0 : VW'(y + 1);
         if (s_exp) m_buf = ~m_buf;
         if (underrun_clr) m_cnt = u_exp ? 1 : 0;
         else if (u_exp && m_cnt < UMAX) m_cnt++;
      end
   end

   initial begin
      #200000;
      check_eq("watchdog", 0, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset_checks("rst");
      reset  = 1'b0;
      mon_en = 1'b1;

      // one full frame with engines finishing 3 clk after start
      repeat (FRAME) @(posedge clk);
      // engine 0 slow, spurious done[1] while waiting on engine 0
      to_line_y(1);
      dly0 = 5; spur = 1'b1;
      // engine 1 finishes exactly on the line-end clock
      to_line_y(2);
      dly0 = 3; spur = 1'b0; dly1 = 0; d1_le = 1'b1;
      // engine 1 never finishes: underruns on lines 6,0,1,2 saturate the count
      to_line_y(3);
      d1_le = 1'b0;
      to_line_y(3);
      clr_arm = 1'b1; clr_y = 3; clr_pos = 10;
      // clear coinciding with an underrun leaves a count of one
      to_line_y(4);
      clr_arm = 1'b1; clr_y = VT - 1; clr_pos = LINE - 1;
      // reset while waiting on engine 1
      to_line_y(0);
      wait_pos(15);
      check_eq("state_wait1", 32'(state_dbg), 2);
      mon_en = 1'b0;
      reset  = 1'b1;
      #1;
      reset_checks("midrst");
      start_q.delete();
      exp_q.delete();
      m_buf = 1'b0; m_cnt = 0; m_render = '0;
      dly0 = 3; dly1 = 3;
      repeat (2) @(posedge clk);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;
      repeat (FRAME + 4) @(posedge clk);
      #1;
      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
